// File: rtl/mesh_fetch_param.sv
// mesh_fetch_param
// Walks a rectangular mesh of squares stored in memory, reads the four corner
// destination coordinates of each square over a read-only WISHBONE master and
// emits two triangles per square (destination + source vertices) to an
// interpolator. Horizontally adjacent squares share an edge, so after the first
// square of a row only the right-hand corners are fetched.
//
// Ports
//   clk, rst                    clock (rising edge), async active-high reset
//   mwb_adr_o/cyc_o/stb_o       WISHBONE read request (byte address)
//   mwb_ack_i, mwb_dat_i        WISHBONE response; x = [CW-1:0], y = [16+CW-1:16]
//   meshaddr                    base word address (x field [MW-1:0], y [29:MW])
//   mesh_count_x/_y             squares per axis minus one
//   mesh_size_x/_y              source-grid step per square
//   diag                        triangle split selection
//   start, abort                frame control; finished is high only in IDLE
//   t_da..t_sc                  triangle vertices {y,x}, d = dest, s = source
//   t_load, t_finished          triangle load strobe / interpolator ready
module mesh_fetch_param #(
  parameter int CW = 11,
  parameter int MW = 7
) (
  input  logic            clk,
  input  logic            rst,
  output logic [31:0]     mwb_adr_o,
  output logic            mwb_cyc_o,
  output logic            mwb_stb_o,
  input  logic            mwb_ack_i,
  input  logic [31:0]     mwb_dat_i,
  input  logic [29:0]     meshaddr,
  input  logic [MW-1:0]   mesh_count_x,
  input  logic [MW-1:0]   mesh_count_y,
  input  logic [CW-1:0]   mesh_size_x,
  input  logic [CW-1:0]   mesh_size_y,
  input  logic            diag,
  input  logic            start,
  input  logic            abort,
  output logic            finished,
  output logic [2*CW-1:0] t_da,
  output logic [2*CW-1:0] t_sa,
  output logic [2*CW-1:0] t_db,
  output logic [2*CW-1:0] t_sb,
  output logic [2*CW-1:0] t_dc,
  output logic [2*CW-1:0] t_sc,
  output logic            t_load,
  input  logic            t_finished
);

  localparam int YW = 30 - MW;
  localparam int VW = 2 * CW;
  localparam logic [MW-1:0] X_ONE  = {{(MW-1){1'b0}}, 1'b1};
  localparam logic [YW-1:0] Y_ONE  = {{(YW-1){1'b0}}, 1'b1};
  localparam logic [MW-1:0] X_ZERO = {MW{1'b0}};
  localparam logic [CW-1:0] C_ZERO = {CW{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_F_TL = 3'd1,
    S_F_BL = 3'd2,
    S_F_TR = 3'd3,
    S_F_BR = 3'd4,
    S_TRI0 = 3'd5,
    S_TRI1 = 3'd6,
    S_NEXT = 3'd7
  } state_t;

  state_t          state_q, state_d;
  logic [MW-1:0]   adr_x_q, adr_x_d;
  logic [YW-1:0]   adr_y_q, adr_y_d;
  logic [MW-1:0]   rem_x_q, rem_x_d;
  logic [MW-1:0]   rem_y_q, rem_y_d;
  logic [CW-1:0]   src_x0_q, src_x0_d;
  logic [CW-1:0]   src_y0_q, src_y0_d;
  logic [VW-1:0]   dst_tl_q, dst_tl_d;
  logic [VW-1:0]   dst_bl_q, dst_bl_d;
  logic [VW-1:0]   dst_tr_q, dst_tr_d;
  logic [VW-1:0]   dst_br_q, dst_br_d;

  // Frame parameters frozen at start
  logic [MW-1:0]   base_x_q;
  logic [MW-1:0]   cnt_x_q;
  logic [CW-1:0]   size_x_q;
  logic [CW-1:0]   size_y_q;
  logic            diag_q;

  logic            fetch_s;
  logic            tri_s;
  logic            load_s;
  logic            ack_s;
  logic [VW-1:0]   dat_coord_s;
  logic [CW-1:0]   src_x1_s;
  logic [CW-1:0]   src_y1_s;
  logic [VW-1:0]   src_tl_s, src_tr_s, src_bl_s, src_br_s;
  logic            dat_unused_s;

  assign fetch_s     = (state_q == S_F_TL) || (state_q == S_F_BL) ||
                       (state_q == S_F_TR) || (state_q == S_F_BR);
  assign tri_s       = (state_q == S_TRI0) || (state_q == S_TRI1);
  assign load_s      = (state_q == S_IDLE) && start;
  assign ack_s       = mwb_ack_i && !abort;
  assign dat_coord_s = {mwb_dat_i[16+CW-1:16], mwb_dat_i[CW-1:0]};
  // Bits of the data word outside the coordinate fields are intentionally ignored
  assign dat_unused_s = ^mwb_dat_i;

  // Bus request drops combinationally on abort so no read completes that cycle
  assign mwb_cyc_o = fetch_s && !abort;
  assign mwb_stb_o = fetch_s && !abort;
  assign mwb_adr_o = {adr_y_q, adr_x_q, 2'b00};
  assign finished  = (state_q == S_IDLE);
  assign t_load    = tri_s && t_finished && !abort;

  // Source vertices are derived from the top-left origin of the current square
  assign src_x1_s = src_x0_q + size_x_q;
  assign src_y1_s = src_y0_q + size_y_q;
  assign src_tl_s = {src_y0_q, src_x0_q};
  assign src_tr_s = {src_y0_q, src_x1_s};
  assign src_bl_s = {src_y1_s, src_x0_q};
  assign src_br_s = {src_y1_s, src_x1_s};

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      adr_x_q  <= {MW{1'b0}};
      adr_y_q  <= {YW{1'b0}};
      rem_x_q  <= {MW{1'b0}};
      rem_y_q  <= {MW{1'b0}};
      src_x0_q <= {CW{1'b0}};
      src_y0_q <= {CW{1'b0}};
      dst_tl_q <= {VW{1'b0}};
      dst_bl_q <= {VW{1'b0}};
      dst_tr_q <= {VW{1'b0}};
      dst_br_q <= {VW{1'b0}};
    end else begin
      state_q  <= state_d;
      adr_x_q  <= adr_x_d;
      adr_y_q  <= adr_y_d;
      rem_x_q  <= rem_x_d;
      rem_y_q  <= rem_y_d;
      src_x0_q <= src_x0_d;
      src_y0_q <= src_y0_d;
      dst_tl_q <= dst_tl_d;
      dst_bl_q <= dst_bl_d;
      dst_tr_q <= dst_tr_d;
      dst_br_q <= dst_br_d;
    end
  end

  // Frame parameter latch, loaded only when a frame starts from IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_x_q <= {MW{1'b0}};
      cnt_x_q  <= {MW{1'b0}};
      size_x_q <= {CW{1'b0}};
      size_y_q <= {CW{1'b0}};
      diag_q   <= 1'b0;
    end else if (load_s) begin
      base_x_q <= meshaddr[MW-1:0];
      cnt_x_q  <= mesh_count_x;
      size_x_q <= mesh_size_x;
      size_y_q <= mesh_size_y;
      diag_q   <= diag;
    end else begin
      base_x_q <= base_x_q;
      cnt_x_q  <= cnt_x_q;
      size_x_q <= size_x_q;
      size_y_q <= size_y_q;
      diag_q   <= diag_q;
    end
  end

  // Next-state logic; abort takes priority over ack and t_finished
  always_comb begin
    state_d  = state_q;
    adr_x_d  = adr_x_q;
    adr_y_d  = adr_y_q;
    rem_x_d  = rem_x_q;
    rem_y_d  = rem_y_q;
    src_x0_d = src_x0_q;
    src_y0_d = src_y0_q;
    dst_tl_d = dst_tl_q;
    dst_bl_d = dst_bl_q;
    dst_tr_d = dst_tr_q;
    dst_br_d = dst_br_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_F_TL;
          adr_x_d  = meshaddr[MW-1:0];
          adr_y_d  = meshaddr[29:MW];
          rem_x_d  = mesh_count_x;
          rem_y_d  = mesh_count_y;
          src_x0_d = C_ZERO;
          src_y0_d = C_ZERO;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_F_TL: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (ack_s) begin
          dst_tl_d = dat_coord_s;
          adr_y_d  = adr_y_q + Y_ONE;
          state_d  = S_F_BL;
        end else begin
          state_d = S_F_TL;
        end
      end
      S_F_BL: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (ack_s) begin
          dst_bl_d = dat_coord_s;
          adr_x_d  = adr_x_q + X_ONE;
          adr_y_d  = adr_y_q - Y_ONE;
          state_d  = S_F_TR;
        end else begin
          state_d = S_F_BL;
        end
      end
      S_F_TR: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (ack_s) begin
          dst_tr_d = dat_coord_s;
          adr_y_d  = adr_y_q + Y_ONE;
          state_d  = S_F_BR;
        end else begin
          state_d = S_F_TR;
        end
      end
      S_F_BR: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (ack_s) begin
          dst_br_d = dat_coord_s;
          adr_y_d  = adr_y_q - Y_ONE;
          state_d  = S_TRI0;
        end else begin
          state_d = S_F_BR;
        end
      end
      S_TRI0: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (t_finished) begin
          state_d = S_TRI1;
        end else begin
          state_d = S_TRI0;
        end
      end
      S_TRI1: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (t_finished) begin
          state_d = S_NEXT;
        end else begin
          state_d = S_TRI1;
        end
      end
      S_NEXT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (rem_x_q != X_ZERO) begin
          // Right edge becomes the left edge of the next square
          dst_tl_d = dst_tr_q;
          dst_bl_d = dst_br_q;
          src_x0_d = src_x0_q + size_x_q;
          adr_x_d  = adr_x_q + X_ONE;
          rem_x_d  = rem_x_q - X_ONE;
          state_d  = S_F_TR;
        end else if (rem_y_q != X_ZERO) begin
          adr_x_d  = base_x_q;
          adr_y_d  = adr_y_q + Y_ONE;
          rem_x_d  = cnt_x_q;
          rem_y_d  = rem_y_q - X_ONE;
          src_x0_d = C_ZERO;
          src_y0_d = src_y0_q + size_y_q;
          state_d  = S_F_TL;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Triangle vertex selection; only registered values feed it, so it is stable in TRI0/TRI1
  always_comb begin
    t_da = dst_tl_q;
    t_sa = src_tl_s;
    t_db = dst_bl_q;
    t_sb = src_bl_s;
    t_dc = dst_tr_q;
    t_sc = src_tr_s;
    if (state_q == S_TRI1) begin
      if (diag_q) begin
        t_da = dst_bl_q;  t_sa = src_bl_s;
        t_db = dst_br_q;  t_sb = src_br_s;
        t_dc = dst_tl_q;  t_sc = src_tl_s;
      end else begin
        t_da = dst_br_q;  t_sa = src_br_s;
        t_db = dst_bl_q;  t_sb = src_bl_s;
        t_dc = dst_tr_q;  t_sc = src_tr_s;
      end
    end else begin
      if (diag_q) begin
        t_da = dst_tr_q;  t_sa = src_tr_s;
        t_db = dst_tl_q;  t_sb = src_tl_s;
        t_dc = dst_br_q;  t_sc = src_br_s;
      end else begin
        t_da = dst_tl_q;  t_sa = src_tl_s;
        t_db = dst_bl_q;  t_sb = src_bl_s;
        t_dc = dst_tr_q;  t_sc = src_tr_s;
      end
    end
  end

endmodule
